booth_mult_arbiter: RTL and testbench

- Shares one Booth multiplier (controller plus datapath) between two requesters.
- Grants one request at a time, latches its operands, and pulses the multiplier `start`.
- Captures the two-word product: the high word arrives on the first `done` cycle, the low word on the second.
- Returns the product to the granted requester with a one-cycle ack.

---
 rtl/booth_mult_arbiter.sv | 174 +++++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: shares one Booth multiplier between two requesters.
// One request is granted at a time and its operands are latched. The
// multiplier gets a one-cycle start pulse. The two product words are
// collected from m_bus: the high word on the first done cycle, the low word
// on the second. The product goes back to the owner with a one-cycle ack.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, ties are
// resolved round robin. When it is undefined, requester 0 has fixed priority.
module booth_mult_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req0,
    input  logic [WIDTH-1:0]   i_x0,
    input  logic [WIDTH-1:0]   i_y0,
    output logic               o_ack0,
    input  logic               i_req1,
    input  logic [WIDTH-1:0]   i_x1,
    input  logic [WIDTH-1:0]   i_y1,
    output logic               o_ack1,
    output logic [2*WIDTH-1:0] o_result,
    output logic               o_grant_id,
    output logic               o_busy,
    output logic               o_err,
    output logic               o_m_start,
    output logic [WIDTH-1:0]   o_m_x,
    output logic [WIDTH-1:0]   o_m_y,
    input  logic               i_m_done,
    input  logic [WIDTH-1:0]   i_m_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_LO,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic                 r_grant_id;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_err;
    logic                 w_any_req;
    logic                 w_winner;
    logic                 w_m_start;
    logic                 w_drive;
    logic                 w_ack;

    assign w_any_req = i_req0 | i_req1;

`ifdef ARB_ROUND_ROBIN_EN
    // r_ptr holds the last grant. Its reset value of 1 lets requester 0 win the first tie.
    logic r_ptr;

    // Winner select: on a tie, grant the requester that was not served last.
    always_comb begin
        w_winner = i_req1;
        if (i_req0 && i_req1) begin
            w_winner = ~r_ptr;
        end
    end

    // Update the pointer on every grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_ptr <= w_winner;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is asking.
    assign w_winner = ~i_req0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state controls. m_done seen in START is ignored.
    always_comb begin
        w_state_next = r_state;
        w_m_start    = 1'b0;
        w_drive      = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_m_start    = 1'b1;
                w_drive      = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_drive = 1'b1;
                if (i_m_done) begin
                    w_state_next = S_LO;
                end
            end
            S_LO: begin
                w_drive      = 1'b1;
                w_state_next = S_ACK;
            end
            S_ACK: begin
                w_ack        = 1'b1;
                w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, grant owner, product word capture and the sticky error flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_grant_id <= 1'b0;
            r_result   <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_winner;
                        r_x        <= w_winner ? i_x1 : i_x0;
                        r_y        <= w_winner ? i_y1 : i_y0;
                    end
                end
                S_WAIT: begin
                    if (i_m_done) begin
                        r_result[2*WIDTH-1:WIDTH] <= i_m_bus;
                    end
                end
                S_LO: begin
                    r_result[WIDTH-1:0] <= i_m_bus;
                    if (!i_m_done) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_m_start  = w_m_start;
    assign o_m_x      = w_drive ? r_x : '0;
    assign o_m_y      = w_drive ? r_y : '0;
    assign o_ack0     = w_ack & ~r_grant_id;
    assign o_ack1     = w_ack & r_grant_id;
    assign o_result   = r_result;
    assign o_grant_id = r_grant_id;
    assign o_busy     = (r_state != S_IDLE);
    assign o_err      = r_err;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter. The bench contains:
//  - a behavioural Booth multiplier that answers every start pulse,
//  - a queue-driven requester model for the two requesters,
//  - a scoreboard of expected acks, each holding owner, operands, product and err.
// Build with +define+ARB_ROUND_ROBIN_EN to add the round-robin sequence.
module tb_booth_mult_arbiter;

    localparam int W = 8;
    localparam int D = 3;   // model: negedges from start to the first done cycle

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_v;
    logic [W-1:0] x0, y0, x1, y1;
    logic         ack0, ack1;
    logic [2*W-1:0] result;
    logic         grant_id, busy, err, m_start;
    logic [W-1:0] m_x, m_y;
    logic         m_done;
    logic [W-1:0] m_bus;

    typedef struct {
        logic         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2*W-1:0] res;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    logic [15:0]  op0[$];
    logic [15:0]  op1[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         early_done;
    logic         short_done;

    booth_mult_arbiter #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req0     (req_v[0]),
        .i_x0       (x0),
        .i_y0       (y0),
        .o_ack0     (ack0),
        .i_req1     (req_v[1]),
        .i_x1       (x1),
        .i_y1       (y1),
        .o_ack1     (ack1),
        .o_result   (result),
        .o_grant_id (grant_id),
        .o_busy     (busy),
        .o_err      (err),
        .o_m_start  (m_start),
        .o_m_x      (m_x),
        .o_m_y      (m_y),
        .i_m_done   (m_done),
        .i_m_bus    (m_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic push_exp(input logic id, input logic [7:0] x, input logic [7:0] y,
                            input logic [15:0] res, input logic e);
        exp_t t;
        t.id = id; t.x = x; t.y = y; t.res = res; t.err = e;
        exp_q.push_back(t);
        if (id) op1.push_back({x, y});
        else    op0.push_back({x, y});
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Requester model: raise req with the next queued operands. Drop req on ack.
    // Re-raise no earlier than the cycle after the ack.
    initial begin
        req_v = 2'b00;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                req_v = 2'b00;
                op0.delete();
                op1.delete();
            end else begin
                if (ack0) req_v[0] = 1'b0;
                if (ack1) req_v[1] = 1'b0;
                if (!req_v[0] && !ack0 && op0.size() > 0) begin
                    {x0, y0} = op0.pop_front();
                    req_v[0] = 1'b1;
                end
                if (!req_v[1] && !ack1 && op1.size() > 0) begin
                    {x1, y1} = op1.pop_front();
                    req_v[1] = 1'b1;
                end
            end
        end
    end

    // Booth multiplier model. It loads X and then Y in the two cycles after start.
    // It then presents the high word and the low word on two done cycles.
    initial begin
        int mcnt;
        logic signed [W-1:0]   mx, my;
        logic signed [2*W-1:0] prod;
        mcnt = 0; mx = '0; my = '0; prod = '0;
        m_done = 1'b0; m_bus = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0; m_done = 1'b0; m_bus = '0;
            end else if (mcnt == 0) begin
                m_done = 1'b0;
                if (m_start) begin
                    mcnt = 1;
                    if (early_done) begin
                        m_done = 1'b1;
                        m_bus  = 8'hAA;
                    end
                end
            end else begin
                m_done = 1'b0;
                if (mcnt == 1) begin
                    mx = m_x;
                    if (exp_q.size() > 0) check("m_x_load", m_x, exp_q[0].x);
                end
                if (mcnt == 2) begin
                    my = m_y;
                    prod = mx * my;
                    if (exp_q.size() > 0) begin
                        check("m_x_held", m_x, exp_q[0].x);
                        check("m_y_load", m_y, exp_q[0].y);
                    end
                end
                if (mcnt == D) begin
                    m_done = 1'b1;
                    m_bus  = prod[2*W-1:W];
                end
                if (mcnt == D + 1) begin
                    m_done = !short_done;
                    m_bus  = prod[W-1:0];
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
        end
    end

    // Compare process: acks against the scoreboard, plus per-cycle protocol rules.
    initial begin
        int   since_start;
        int   since_ack;
        logic prev_start;
        exp_t e;
        since_start = -1; since_ack = -1; prev_start = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                since_start = -1; since_ack = -1; prev_start = 1'b0;
            end else begin
                check("ack_onehot", {31'd0, ack0 & ack1}, 0);
                if (m_start) begin
                    check("start_single_cycle", prev_start, 0);
                    since_start = 0;
                end else if (since_start >= 0) begin
                    since_start++;
                end
                prev_start = m_start;
                if (ack0 || ack1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ack", {ack1, ack0}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn id=%0d x=%0h y=%0h result=%0h err=%0d", ack1, e.x, e.y, result, err);
                        check("ack_id", ack1, e.id);
                        check("grant_id", grant_id, e.id);
                        check("result", result, e.res);
                        check("err_at_ack", err, e.err);
                        check("latency", since_start, D + 2);
                    end
                    since_ack = 0;
                    since_start = -1;
                end else if (since_ack >= 0) begin
                    since_ack++;
                    if (since_ack == 1) check("busy_in_release", busy, 1);
                    if (since_ack == 2) begin
                        check("busy_after_release", busy, 0);
                        since_ack = -1;
                    end
                end
            end
        end
    end

    task automatic check_reset_state();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_m_start", m_start, 0);
        check("rst_result", result, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_m_x", m_x, 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b1; early_done = 1'b0; short_done = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic product for requester 0: 5*3.
        @(negedge clk);
        push_exp(1'b0, 8'd5, 8'd3, 16'h000F, 1'b0);
        drain();

        // Signed product for requester 1: -3*7.
        push_exp(1'b1, 8'hFD, 8'd7, 16'hFFEB, 1'b0);
        drain();

        // Both requesters raised together: requester 0 is served first.
        push_exp(1'b0, 8'd20, 8'hF6, smul(8'd20, 8'hF6), 1'b0);
        push_exp(1'b1, 8'h7F, 8'h03, smul(8'h7F, 8'h03), 1'b0);
        drain();

        // A stray done during START must be ignored.
        early_done = 1'b1;
        push_exp(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
        drain();
        early_done = 1'b0;

        // A single-cycle done sets err and still produces an ack.
        short_done = 1'b1;
        push_exp(1'b0, 8'd100, 8'hCE, 16'hEC78, 1'b1);
        drain();
        short_done = 1'b0;

        // The next transaction completes normally and err stays set.
        push_exp(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
        drain();

        // Reset while in WAIT aborts the transaction with no ack.
        op0.push_back({8'd9, 8'd9});
        t = 0;
        while (!m_start && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_start_seen", m_start, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(1'b0, 8'd12, 8'd12, 16'h0090, 1'b0);
        drain();

`ifdef ARB_ROUND_ROBIN_EN
        // Both requesters stay armed for four transactions: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(1'b0, 8'd2,   8'hFC, 16'hFFF8, 1'b0);
        push_exp(1'b1, 8'd11,  8'd6,  16'h0042, 1'b0);
        push_exp(1'b0, 8'hF9,  8'hF7, 16'h003F, 1'b0);
        push_exp(1'b1, 8'h80,  8'h7F, 16'hC080, 1'b0);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
